// File: rtl/seg7_pkg.sv
// Shared glyph constants (active-high, g..a) and FSM state type for the
// 7-segment reader.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    TRACK   = 1'b0,
    SETTLED = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-high 7-segment pattern to its hex digit.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal,
  output logic       is_blank
);

  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_A:   digit = 4'hA;
      SEG_B:   digit = 4'hB;
      SEG_C:   digit = 4'hC;
      SEG_D:   digit = 4'hD;
      SEG_E:   digit = 4'hE;
      SEG_F:   digit = 4'hF;
      default: legal = 1'b0;
    endcase
    is_blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples an active-low 7-segment bus, waits for a stable pattern and decodes it
// to a hex digit. Define SEG7_READER_SYNC_EN for a two-flop input synchronizer.
//
// state   | meaning
// TRACK   | sample changed recently, waiting for it to hold STABLE_CYCLES
// SETTLED | sample stable and already evaluated
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg7,
  output logic [3:0]       hex,
  output logic             hex_valid,
  output logic             blank,
  output logic             hex_stb,
  output logic             err_stb,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int              CNT_W     = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]      BUS_BLANK = 7'h7F;

  logic [6:0]       samp_q;
  logic [6:0]       prev_q;
  logic [6:0]       acc_q;
  logic [6:0]       samp_hi;
  logic [CNT_W-1:0] cnt_q;
  logic             changed;
  logic             accept;
  logic [3:0]       lut_digit;
  logic             lut_legal;
  logic             lut_blank;
  state_t           state_q, state_d;

`ifdef SEG7_READER_SYNC_EN
  logic [6:0] sync1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= BUS_BLANK;
      samp_q  <= BUS_BLANK;
    end else begin
      sync1_q <= seg7;
      samp_q  <= sync1_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samp_q <= BUS_BLANK;
    else        samp_q <= seg7;
  end
`endif

  assign changed = (samp_q != prev_q);
  assign samp_hi = ~samp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= BUS_BLANK;
      cnt_q  <= '0;
    end else begin
      prev_q <= samp_q;
      if (changed)              cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SETTLED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      TRACK: begin
        if (!changed && cnt_q == CNT_MAX) begin
          state_d = SETTLED;
          accept  = 1'b1;
        end
      end
      SETTLED: begin
        if (changed) state_d = TRACK;
      end
      default: state_d = SETTLED;
    endcase
  end

  seg7_to_hex u_lut (
    .pattern  (samp_hi),
    .digit    (lut_digit),
    .legal    (lut_legal),
    .is_blank (lut_blank)
  );

  // Re-settling on the already accepted pattern is deliberately silent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= BUS_BLANK;
      hex       <= 4'h0;
      hex_valid <= 1'b0;
      blank     <= 1'b1;
      hex_stb   <= 1'b0;
      err_stb   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      hex_stb <= 1'b0;
      err_stb <= 1'b0;
      if (accept && samp_q != acc_q) begin
        acc_q <= samp_q;
        if (lut_legal) begin
          hex       <= lut_digit;
          hex_valid <= 1'b1;
          blank     <= 1'b0;
          hex_stb   <= 1'b1;
        end else if (lut_blank) begin
          hex_valid <= 1'b0;
          blank     <= 1'b1;
        end else begin
          hex_valid <= 1'b0;
          blank     <= 1'b0;
          err_stb   <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: expected strobes are queued when a pattern
// is driven and matched when the DUT strobes; a second instance uses ERR_W=2.
module tb_seg7_reader;

`ifdef SEG7_READER_SYNC_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 1 + 4;
`endif

  typedef struct {
    bit         is_err;
    logic [3:0] hex;
    int         err;
    int         due;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [6:0] seg7;
  logic [3:0] hex;
  logic       hex_valid, blank, hex_stb, err_stb;
  logic [7:0] err_cnt;
  logic [3:0] d2_hex;
  logic       d2_hex_valid, d2_blank, d2_hex_stb, d2_err_stb;
  logic [1:0] d2_err_cnt;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  n2_err = 0;
  ev_t sbq[$];

  logic [6:0] glyph [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic [6:0] m_acc = 7'h7F;
  logic [3:0] m_hex = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_blank = 1'b1;
  int         m_err = 0;

  seg7_reader dut (
    .clk(clk), .reset(reset), .seg7(seg7), .hex(hex), .hex_valid(hex_valid),
    .blank(blank), .hex_stb(hex_stb), .err_stb(err_stb), .err_cnt(err_cnt)
  );

  seg7_reader #(.STABLE_CYCLES(4), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .seg7(seg7), .hex(d2_hex), .hex_valid(d2_hex_valid),
    .blank(d2_blank), .hex_stb(d2_hex_stb), .err_stb(d2_err_stb), .err_cnt(d2_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_steady();
    chk("hex", 32'(hex), 32'(m_hex));
    chk("hex_valid", 32'(hex_valid), 32'(m_valid));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  // Model update for a newly stable pattern at bus level.
  task automatic model_accept(input logic [6:0] pat_hi, input int start_cyc);
    ev_t e;
    bit  legal = 1'b0;
    logic [3:0] dg = 4'h0;
    if (~pat_hi == m_acc) return;
    m_acc = ~pat_hi;
    for (int i = 0; i < 16; i++)
      if (glyph[i] == pat_hi) begin legal = 1'b1; dg = 4'(i); end
    if (legal) begin
      m_hex = dg; m_valid = 1'b1; m_blank = 1'b0;
      e.is_err = 1'b0; e.hex = dg; e.err = m_err; e.due = start_cyc + 1 + LAT;
      sbq.push_back(e);
    end else if (pat_hi == 7'b0000000) begin
      m_valid = 1'b0; m_blank = 1'b1;
    end else begin
      if (m_err < 255) m_err++;
      m_valid = 1'b0; m_blank = 1'b0;
      e.is_err = 1'b1; e.hex = m_hex; e.err = m_err; e.due = start_cyc + 1 + LAT;
      sbq.push_back(e);
    end
  endtask

  task automatic drive(input logic [6:0] pat_hi, input int n);
    int d;
    @(posedge clk); #1;
    seg7 = ~pat_hi;
    d = cyc;
    if (n > LAT) model_accept(pat_hi, d);
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_steady();
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (reset && d2_err_stb) n2_err++;
    if (reset && (hex_stb || err_stb)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_stb", 32'({hex_stb, err_stb}), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("stb_cycle", 32'(cyc), 32'(e.due));
        chk("stb_kind", 32'({hex_stb, err_stb}), e.is_err ? 32'h1 : 32'h2);
        chk("stb_hex", 32'(hex), 32'(e.hex));
        chk("stb_err_cnt", 32'(err_cnt), 32'(e.err));
        chk("stb_valid", 32'(hex_valid), e.is_err ? 32'h0 : 32'h1);
        chk("stb_blank", 32'(blank), 32'h0);
      end
    end
  end

  initial begin
    int d;
    seg7  = 7'h7F;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_steady();
    chk("rst_hex_stb", 32'(hex_stb), 32'h0);
    chk("rst_err_stb", 32'(err_stb), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    drive(glyph[1], 10);
    drive(7'b1111100, 3);
    drive(glyph[1], 10);
    for (int i = 0; i < 16; i++) drive(glyph[i], 8);
    drive(7'b1010101, 8);
    drive(7'b0000000, 8);
    drive(glyph[2], 8);

    n2_err = 0;
    for (int k = 0; k < 5; k++) drive((k % 2 == 0) ? 7'b1010101 : 7'b0101010, 8);
    chk("d2_err_pulses", 32'(n2_err), 32'd5);
    chk("d2_err_sat", 32'(d2_err_cnt), 32'd3);

    // Reset two cycles into a fresh pattern, while the reader is tracking.
    @(posedge clk); #1;
    seg7 = ~glyph[5];
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_acc = 7'h7F; m_hex = 4'h0; m_valid = 1'b0; m_blank = 1'b1; m_err = 0;
    @(negedge clk);
    check_steady();
    chk("rst_d2_err_cnt", 32'(d2_err_cnt), 32'h0);
    chk("rst_mid_hex_stb", 32'(hex_stb), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    d = cyc;
    model_accept(glyph[5], d);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_steady();

    for (int w = 0; w < 50 && sbq.size() != 0; w++) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
